// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: Mealy control of PC, IF_ID, ID_EX and EX_MEM enables/flushes
// from load-use hazards, EX redirects, multi-cycle MDU ops and debug halt, plus saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32,
    parameter int MDU_TIMEOUT    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rs2_addr_i,
    input  logic                      ID_rs1_used_i,
    input  logic                      ID_rs2_used_i,
    input  logic [REG_ADDR_WIDTH-1:0] EX_rd_addr_i,
    input  logic                      EX_mem_read_i,
    input  logic                      EX_branch_taken_i,
    input  logic                      EX_mdu_start_i,
    input  logic                      mdu_done_i,
    input  logic                      halt_req_i,
    output logic                      pc_write_en_o,
    output logic                      IF_ID_write_en_o,
    output logic                      IF_ID_flush_o,
    output logic                      ID_EX_write_en_o,
    output logic                      ID_EX_flush_o,
    output logic                      EX_MEM_flush_o,
    output logic                      halted_o,
    output logic                      mdu_timeout_o,
    output logic [CNT_WIDTH-1:0]      stall_cycles_o,
    output logic [CNT_WIDTH-1:0]      flush_count_o
);

    localparam int TW = $clog2(MDU_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          load_use;
    logic          mdu_stall;
    logic          timer_last;
    logic          stall_evt;
    logic          redirect_evt;
    logic          timeout_evt;

    always_comb begin
        load_use = EX_mem_read_i && (EX_rd_addr_i != '0) &&
                   ((ID_rs1_used_i && (ID_rs1_addr_i == EX_rd_addr_i)) ||
                    (ID_rs2_used_i && (ID_rs2_addr_i == EX_rd_addr_i)));
        // A start that completes in the same cycle never needs to freeze the pipe.
        mdu_stall  = EX_mdu_start_i && !mdu_done_i;
        timer_last = (timer == TW'(MDU_TIMEOUT - 1));
    end

    always_comb begin
        pc_write_en_o    = 1'b0;
        IF_ID_write_en_o = 1'b0;
        IF_ID_flush_o    = 1'b0;
        ID_EX_write_en_o = 1'b0;
        ID_EX_flush_o    = 1'b0;
        EX_MEM_flush_o   = 1'b0;
        redirect_evt     = 1'b0;
        timeout_evt      = 1'b0;
        if (!rst) begin
            pc_write_en_o    = 1'b1;
            IF_ID_write_en_o = 1'b1;
            ID_EX_write_en_o = 1'b1;
            case (state)
                ST_RUN: begin
                    if (mdu_stall) begin
                        pc_write_en_o    = 1'b0;
                        IF_ID_write_en_o = 1'b0;
                        ID_EX_write_en_o = 1'b0;
                        EX_MEM_flush_o   = 1'b1;
                    end else if (EX_branch_taken_i) begin
                        IF_ID_flush_o = 1'b1;
                        ID_EX_flush_o = 1'b1;
                        redirect_evt  = 1'b1;
                    end else if (load_use) begin
                        pc_write_en_o    = 1'b0;
                        IF_ID_write_en_o = 1'b0;
                        ID_EX_flush_o    = 1'b1;
                    end else if (halt_req_i) begin
                        pc_write_en_o    = 1'b0;
                        IF_ID_write_en_o = 1'b0;
                        ID_EX_write_en_o = 1'b0;
                    end
                end
                ST_MDU_WAIT: begin
                    if (!mdu_done_i && !timer_last) begin
                        pc_write_en_o    = 1'b0;
                        IF_ID_write_en_o = 1'b0;
                        ID_EX_write_en_o = 1'b0;
                        EX_MEM_flush_o   = 1'b1;
                    end else if (!mdu_done_i) begin
                        timeout_evt = 1'b1;
                    end
                end
                ST_HALTED: begin
                    pc_write_en_o    = 1'b0;
                    IF_ID_write_en_o = 1'b0;
                    ID_EX_write_en_o = 1'b0;
                end
                default: ;
            endcase
        end
        stall_evt = !rst && (state != ST_HALTED) && !pc_write_en_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_RUN;
            timer          <= '0;
            halted_o       <= 1'b0;
            mdu_timeout_o  <= 1'b0;
            stall_cycles_o <= '0;
            flush_count_o  <= '0;
        end else begin
            mdu_timeout_o <= timeout_evt;
            if (stall_evt && (stall_cycles_o != '1))
                stall_cycles_o <= stall_cycles_o + CNT_WIDTH'(1);
            if (redirect_evt && (flush_count_o != '1))
                flush_count_o <= flush_count_o + CNT_WIDTH'(1);
            case (state)
                ST_RUN: begin
                    if (mdu_stall) begin
                        state <= ST_MDU_WAIT;
                        timer <= '0;
                    end else if (!EX_branch_taken_i && !load_use && halt_req_i) begin
                        state    <= ST_HALTED;
                        halted_o <= 1'b1;
                    end
                end
                ST_MDU_WAIT: begin
                    if (mdu_done_i || timer_last)
                        state <= ST_RUN;
                    else
                        timer <= timer + TW'(1);
                end
                ST_HALTED: begin
                    if (!halt_req_i) begin
                        state    <= ST_RUN;
                        halted_o <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    halted_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
